// File: rtl/clock_freq_monitor.sv
// clock_freq_monitor: counts rising edges of NUM_CH monitored clocks over a
// programmable window of clk_ext cycles and flags channels whose count falls
// outside [lo_thr, hi_thr].
//
// Ports:
//   clk_ext    reference clock; all control and outputs live in this domain
//   rst_n      asynchronous active-low reset (also resets clk_mon-domain toggles)
//   clk_mon    monitored clocks, f_mon <= 0.66 * f_clk_ext
//   en         level enable for continuous measurement
//   win_len    window length in clk_ext cycles (0 behaves as 1)
//   lo_thr     minimum acceptable count, inclusive
//   hi_thr     maximum acceptable count, inclusive
//   fault_clr  one-cycle pulse clearing all fault bits
//   cnt_out    last reported counts, channel i at [i*CNT_W +: CNT_W]
//   cnt_valid  one-cycle pulse when cnt_out updates
//   fault      sticky out-of-range flags
//   busy       high whenever the FSM is not IDLE
module clock_freq_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk_ext,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       clk_mon,
    input  logic                    en,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [CNT_W-1:0]        lo_thr,
    input  logic [CNT_W-1:0]        hi_thr,
    input  logic                    fault_clr,
    output logic [NUM_CH*CNT_W-1:0] cnt_out,
    output logic                    cnt_valid,
    output logic [NUM_CH-1:0]       fault,
    output logic                    busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WIN_W-1:0]  win_cnt;
    logic [NUM_CH-1:0] tgl;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] hist;
    logic [NUM_CH-1:0] edge_c;
    logic [NUM_CH-1:0] new_fault_c;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic              clr_cnt_c;
    logic              ld_win_c;
    logic              acc_c;
    logic              rpt_c;

    // Divide-by-2 toggle in each monitored domain; one toggle per clk_mon edge.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_tgl
        logic tgl_q;
        always_ff @(posedge clk_mon[g] or negedge rst_n) begin
            if (!rst_n) tgl_q <= 1'b0;
            else        tgl_q <= ~tgl_q;
        end
        assign tgl[g] = tgl_q;
    end

    // Two-flop synchroniser plus history flop; any difference is one edge.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= tgl;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_c = sync2 ^ hist;

    // State register
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        clr_cnt_c = 1'b0;
        ld_win_c  = 1'b0;
        acc_c     = 1'b0;
        rpt_c     = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt_c = 1'b1;
                if (en) state_nxt = ARM;
            end
            ARM: begin
                clr_cnt_c = 1'b1;
                ld_win_c  = 1'b1;
                state_nxt = MEASURE;
            end
            MEASURE: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    acc_c = 1'b1;
                    if (win_cnt == WIN_W'(1)) state_nxt = REPORT;
                end
            end
            REPORT: begin
                rpt_c     = 1'b1;
                state_nxt = en ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window down-counter; a zero length is stretched to one cycle.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (ld_win_c) begin
            win_cnt <= (win_len == '0) ? WIN_W'(1) : win_len;
        end else if (acc_c) begin
            win_cnt <= win_cnt - WIN_W'(1);
        end
    end

    // Saturating per-channel edge counters
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_cnt_c)
                    cnt_q[i] <= '0;
                else if (acc_c && edge_c[i] && (cnt_q[i] != CNT_MAX))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Range check; an inverted threshold pair faults every channel.
    always_comb begin
        new_fault_c = '0;
        for (int i = 0; i < NUM_CH; i++)
            new_fault_c[i] = (cnt_q[i] < lo_thr) || (cnt_q[i] > hi_thr);
    end

    // Registered outputs; a fault set in REPORT beats a simultaneous clear.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            fault     <= '0;
            busy      <= 1'b0;
        end else begin
            cnt_valid <= rpt_c;
            busy      <= (state_nxt != IDLE);
            fault     <= (fault_clr ? '0 : fault) | (rpt_c ? new_fault_c : '0);
            if (rpt_c) begin
                for (int i = 0; i < NUM_CH; i++)
                    cnt_out[i*CNT_W +: CNT_W] <= cnt_q[i];
            end
        end
    end

endmodule
